// File: rtl/memory_pkg.sv
// Shared memory-subsystem types: error codes, access-size encoding and
// controller state, plus the alignment rule used by the access controller.
package memory_pkg;

    localparam int MEM_BYTES_DEFAULT  = 65536;
    localparam int IMEM_BYTES_DEFAULT = 16384;
    localparam int ERR_ENUMS_WIDTH    = 2;

    typedef enum logic [ERR_ENUMS_WIDTH-1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_ILLEGAL  = 2'd3
    } e_memory_error_codes;

    typedef enum logic [1:0] {
        MEM_WORD = 2'b00,
        MEM_HALF = 2'b01,
        MEM_BYTE = 2'b10,
        MEM_RSVD = 2'b11
    } e_mem_size;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } e_mac_state;

    // Halves need an even address, words a 4-byte aligned one; bytes never fault.
    function automatic logic is_misaligned(input e_mem_size size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            MEM_WORD: mis = (addr_lo != 2'b00);
            MEM_HALF: mis = addr_lo[0];
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage: synchronous byte-enable write and synchronous
// little-endian word read starting at any byte address (wraps at the top).
module mem_byte_array #(
    parameter int MEM_BYTES = 65536,
    parameter int LANES     = 4,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [LANES-1:0]     be,
    input  logic [AW-1:0]        waddr,
    input  logic [8*LANES-1:0]   wdata,
    input  logic [AW-1:0]        raddr,
    output logic [8*LANES-1:0]   rdata
);

    logic [7:0] mem_r [MEM_BYTES];

    // Lane k maps to byte address addr+k on both the write and read side.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (we && be[k]) begin
                mem_r[waddr + AW'(k)] <= wdata[8*k +: 8];
            end
            rdata[8*k +: 8] <= mem_r[raddr + AW'(k)];
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller: checks size, range, alignment and
// instruction-region protection, then accesses memory after fixed wait states.
module mem_access_ctrl
    import memory_pkg::*;
#(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_BYTES     = MEM_BYTES_DEFAULT,
    parameter int IMEM_BYTES    = IMEM_BYTES_DEFAULT,
    parameter int WAIT_STATES   = 1,
    parameter bit IMEM_WRITABLE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_n_bytes,
    input  logic                  req_unsigned,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output e_memory_error_codes   rsp_err
);

    localparam int LANES = WORD_WIDTH / 8;
    localparam int AW    = $clog2(MEM_BYTES);
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT  = (ADDR_WIDTH+1)'(MEM_BYTES);
    localparam logic [ADDR_WIDTH:0] IMEM_LIMIT = (ADDR_WIDTH+1)'(IMEM_BYTES);
    // A zero-wait configuration still spends one cycle in WAIT.
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    e_mac_state          state_r;
    logic [3:0]          wait_cnt_r;
    logic                we_r;
    logic                unsigned_r;
    e_mem_size           size_r;
    logic [AW-1:0]       addr_r;
    logic [WORD_WIDTH-1:0] wdata_r;
    logic                req_ready_r;
    logic                rsp_valid_r;
    logic [WORD_WIDTH-1:0] rsp_rdata_r;
    e_memory_error_codes rsp_err_r;

    e_memory_error_codes req_err_s;
    e_mem_size           req_size_s;
    logic                accept_s;
    logic                commit_s;
    logic                mem_we_s;
    logic [LANES-1:0]    lane_en_s;
    logic [AW-1:0]       mem_raddr_s;
    logic [WORD_WIDTH-1:0] mem_rdata_s;
    logic [WORD_WIDTH-1:0] load_data_s;

    assign req_size_s = e_mem_size'(req_n_bytes);
    assign accept_s   = req_valid && req_ready_r;
    assign commit_s   = (state_r == ST_WAIT) && (wait_cnt_r == 4'd0);

    // Request classification, first matching rule wins.
    always_comb begin
        req_err_s = ERR_OK;
        if (req_size_s == MEM_RSVD) begin
            req_err_s = ERR_ILLEGAL;
        end else if ({1'b0, req_addr} >= MEM_LIMIT) begin
            req_err_s = ERR_RANGE;
        end else if (is_misaligned(req_size_s, req_addr[1:0])) begin
            req_err_s = ERR_MISALIGN;
        end else if (req_we && ({1'b0, req_addr} < IMEM_LIMIT) && !IMEM_WRITABLE) begin
            req_err_s = ERR_ILLEGAL;
        end else begin
            req_err_s = ERR_OK;
        end
    end

    // Memory control; reading from the live request address in IDLE makes the
    // array data ready by the first WAIT cycle. Reset suppresses the commit write.
    always_comb begin
        mem_we_s    = commit_s && we_r && !rst;
        mem_raddr_s = addr_r;
        if (state_r == ST_IDLE) begin
            mem_raddr_s = req_addr[AW-1:0];
        end else begin
            mem_raddr_s = addr_r;
        end
    end

    // Byte lanes touched by the captured access size.
    always_comb begin
        lane_en_s = '0;
        case (size_r)
            MEM_WORD: lane_en_s = '1;
            MEM_HALF: lane_en_s = LANES'(2'b11);
            MEM_BYTE: lane_en_s = LANES'(1'b1);
            default:  lane_en_s = '0;
        endcase
    end

    // Sign or zero extension of sub-word loads.
    always_comb begin
        load_data_s = mem_rdata_s;
        case (size_r)
            MEM_HALF: load_data_s = unsigned_r
                ? {{(WORD_WIDTH-16){1'b0}}, mem_rdata_s[15:0]}
                : {{(WORD_WIDTH-16){mem_rdata_s[15]}}, mem_rdata_s[15:0]};
            MEM_BYTE: load_data_s = unsigned_r
                ? {{(WORD_WIDTH-8){1'b0}}, mem_rdata_s[7:0]}
                : {{(WORD_WIDTH-8){mem_rdata_s[7]}}, mem_rdata_s[7:0]};
            default:  load_data_s = mem_rdata_s;
        endcase
    end

    // Controller FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 4'd0;
            we_r        <= 1'b0;
            unsigned_r  <= 1'b0;
            size_r      <= MEM_WORD;
            addr_r      <= '0;
            wdata_r     <= '0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= ERR_OK;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        we_r        <= req_we;
                        unsigned_r  <= req_unsigned;
                        size_r      <= req_size_s;
                        addr_r      <= req_addr[AW-1:0];
                        wdata_r     <= req_wdata;
                        req_ready_r <= 1'b0;
                        if (req_err_s != ERR_OK) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_rdata_r <= '0;
                            rsp_err_r   <= req_err_s;
                        end else begin
                            state_r    <= ST_WAIT;
                            wait_cnt_r <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (commit_s) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= ERR_OK;
                        rsp_rdata_r <= we_r ? '0 : load_data_s;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                end
            endcase
        end
    end

    mem_byte_array #(
        .MEM_BYTES (MEM_BYTES),
        .LANES     (LANES),
        .AW        (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_s),
        .be    (lane_en_s),
        .waddr (addr_r),
        .wdata (wdata_r),
        .raddr (mem_raddr_s),
        .rdata (mem_rdata_s)
    );

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-level memory model compared every
// cycle, plus directed accesses with hand-computed responses.
module tb_mem_access_ctrl;
    import memory_pkg::*;

    localparam int W      = 3;
    localparam int MEM_B  = 65536;
    localparam int IMEM_B = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [1:0]  req_n_bytes = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_ready = 1'b1;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    mem_access_ctrl #(
        .WORD_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .MEM_BYTES     (MEM_B),
        .IMEM_BYTES    (IMEM_B),
        .WAIT_STATES   (W),
        .IMEM_WRITABLE (1'b0)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_n_bytes  (req_n_bytes),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [7:0]  mem_m [int];
    bit          busy_m = 1'b0;
    bit          vld_m = 1'b0;
    logic [31:0] rdata_m = 32'd0;
    logic [1:0]  err_m = 2'd0;
    int          cyc = 0;
    int          due_m = 0;
    int          acc_m = 0;
    bit          p_we;
    bit          p_uns;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    int          p_n;

    function automatic logic [1:0] model_err(input bit we, input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b11) return 2'd3;
        if (a >= 32'(MEM_B)) return 2'd2;
        if ((sz == 2'b01 && (a % 2) != 0) || (sz == 2'b00 && (a % 4) != 0)) return 2'd1;
        if (we && a < 32'(IMEM_B)) return 2'd3;
        return 2'd0;
    endfunction

    task automatic model_commit();
        logic [31:0] v;
        int idx;
        v = 32'd0;
        for (int k = 0; k < p_n; k++) begin
            idx = int'((p_addr + 32'(k)) % 32'(MEM_B));
            if (p_we) begin
                mem_m[idx] = 8'((p_wdata >> (8 * k)) & 32'hFF);
            end else if (mem_m.exists(idx)) begin
                v = v | (32'(mem_m[idx]) << (8 * k));
            end
        end
        if (!p_uns && p_n == 1 && v[7]) v = v | 32'hFFFFFF00;
        if (!p_uns && p_n == 2 && v[15]) v = v | 32'hFFFF0000;
        rdata_m = p_we ? 32'd0 : v;
        err_m   = 2'd0;
        vld_m   = 1'b1;
    endtask

    always @(posedge clk) begin
        logic [1:0] e;
        cyc++;
        if (rst) begin
            busy_m  = 1'b0;
            vld_m   = 1'b0;
            rdata_m = 32'd0;
            err_m   = 2'd0;
        end else if (!busy_m) begin
            if (req_valid) begin
                acc_m++;
                busy_m  = 1'b1;
                e       = model_err(req_we, req_addr, req_n_bytes);
                p_we    = req_we;
                p_uns   = req_unsigned;
                p_addr  = req_addr;
                p_wdata = req_wdata;
                p_n     = (req_n_bytes == 2'b00) ? 4 : (req_n_bytes == 2'b01) ? 2 : 1;
                if (e != 2'd0) begin
                    vld_m   = 1'b1;
                    err_m   = e;
                    rdata_m = 32'd0;
                end else begin
                    due_m = cyc + ((W == 0) ? 1 : W);
                end
            end
        end else if (!vld_m) begin
            if (cyc == due_m) model_commit();
        end else if (rsp_ready) begin
            vld_m  = 1'b0;
            busy_m = 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_req_ready", 32'(req_ready), 32'(!busy_m));
            chk("cyc_rsp_valid", 32'(rsp_valid), 32'(vld_m));
            chk("cyc_rsp_rdata", rsp_rdata, rdata_m);
            chk("cyc_rsp_err", 32'(rsp_err), 32'(err_m));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input bit we, input logic [31:0] a, input logic [1:0] sz,
                         input bit uns, input logic [31:0] wd);
        req_we       = we;
        req_addr     = a;
        req_n_bytes  = sz;
        req_unsigned = uns;
        req_wdata    = wd;
        req_valid    = 1'b1;
    endtask

    task automatic send(input string nm, input bit we, input logic [31:0] a, input logic [1:0] sz,
                        input bit uns, input logic [31:0] wd, input logic [1:0] e_err,
                        input logic [31:0] e_data);
        int n;
        int lat;
        int prev;
        prev = acc_m;
        drive(we, a, sz, uns, wd);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (acc_m == prev && n < 20);
        req_valid = 1'b0;
        chk({nm, "_accept_cycles"}, 32'(n), 32'd1);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), (e_err == 2'd0) ? 32'(W + 1) : 32'd1);
        chk({nm, "_err"}, 32'(rsp_err), 32'(e_err));
        chk({nm, "_rdata"}, rsp_rdata, e_data);
        chk({nm, "_model_rdata"}, rdata_m, e_data);
        @(posedge clk); #1;
    endtask

    task automatic abort_store(input string nm, input logic [31:0] a, input logic [31:0] wd, input int skip);
        drive(1'b1, a, 2'b00, 1'b0, wd);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (skip) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (W + 2) begin
            @(posedge clk); #1;
            chk({nm, "_no_rsp"}, 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);

        send("st_word",     1'b1, 32'h0000_4000, 2'b00, 1'b0, 32'hDEADBEEF, 2'd0, 32'h0);
        send("ld_word",     1'b0, 32'h0000_4000, 2'b00, 1'b0, 32'h0,        2'd0, 32'hDEADBEEF);
        send("st_byte",     1'b1, 32'h0000_4003, 2'b10, 1'b0, 32'hAAAAAA80, 2'd0, 32'h0);
        send("ld_byte_s",   1'b0, 32'h0000_4003, 2'b10, 1'b0, 32'h0,        2'd0, 32'hFFFFFF80);
        send("ld_byte_u",   1'b0, 32'h0000_4003, 2'b10, 1'b1, 32'h0,        2'd0, 32'h00000080);
        send("ld_word_b",   1'b0, 32'h0000_4000, 2'b00, 1'b0, 32'h0,        2'd0, 32'h80ADBEEF);
        send("st_half_mis", 1'b1, 32'h0000_4001, 2'b01, 1'b0, 32'h00001234, 2'd1, 32'h0);
        send("ld_word_unch",1'b0, 32'h0000_4000, 2'b00, 1'b0, 32'h0,        2'd0, 32'h80ADBEEF);
        send("ld_range",    1'b0, 32'h0001_0000, 2'b00, 1'b0, 32'h0,        2'd2, 32'h0);
        send("ld_range_hi", 1'b0, 32'h8000_4000, 2'b00, 1'b0, 32'h0,        2'd2, 32'h0);
        send("st_imem",     1'b1, 32'h0000_0100, 2'b00, 1'b0, 32'h11111111, 2'd3, 32'h0);
        send("st_imem_top", 1'b1, 32'h0000_3FFF, 2'b10, 1'b0, 32'h00000022, 2'd3, 32'h0);
        send("rsvd_size",   1'b0, 32'h0000_4000, 2'b11, 1'b0, 32'h0,        2'd3, 32'h0);
        send("rsvd_range",  1'b0, 32'h0001_0000, 2'b11, 1'b0, 32'h0,        2'd3, 32'h0);
        send("range_mis",   1'b0, 32'h0001_0001, 2'b01, 1'b0, 32'h0,        2'd2, 32'h0);
        send("ld_word_mis", 1'b0, 32'h0000_4002, 2'b00, 1'b0, 32'h0,        2'd1, 32'h0);
        send("st_dmem_low", 1'b1, 32'h0000_4000, 2'b10, 1'b0, 32'hFFFFFF55, 2'd0, 32'h0);
        send("ld_half_s",   1'b0, 32'h0000_4002, 2'b01, 1'b0, 32'h0,        2'd0, 32'hFFFF80AD);
        send("ld_half_u",   1'b0, 32'h0000_4002, 2'b01, 1'b1, 32'h0,        2'd0, 32'h000080AD);
        send("st_top",      1'b1, 32'h0000_FFFC, 2'b00, 1'b0, 32'h11223344, 2'd0, 32'h0);
        send("ld_top",      1'b0, 32'h0000_FFFC, 2'b00, 1'b0, 32'h0,        2'd0, 32'h11223344);

        // Back-pressure: response held for three cycles with a new request waiting.
        rsp_ready = 1'b0;
        drive(1'b0, 32'h0000_4000, 2'b00, 1'b0, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        drive(1'b0, 32'h0000_4003, 2'b10, 1'b1, 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_valid_held", 32'(rsp_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_rdata_held", rsp_rdata, 32'h80ADBE55);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", 32'(req_ready), 32'd1);
        chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_next_accepted", 32'(req_ready), 32'd0);
        n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("bp_next_rdata", rsp_rdata, 32'h00000080);
        @(posedge clk); #1;

        // Reset during WAIT: second WAIT cycle, then the would-be commit cycle.
        send("st_old",      1'b1, 32'h0000_5000, 2'b00, 1'b0, 32'hCAFEF00D, 2'd0, 32'h0);
        abort_store("rst_wait2", 32'h0000_5000, 32'h12345678, 1);
        send("ld_after_r2", 1'b0, 32'h0000_5000, 2'b00, 1'b0, 32'h0,        2'd0, 32'hCAFEF00D);
        abort_store("rst_wlast", 32'h0000_5000, 32'h12345678, W - 1);
        send("ld_after_rl", 1'b0, 32'h0000_5000, 2'b00, 1'b0, 32'h0,        2'd0, 32'hCAFEF00D);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

endmodule
